// File: rtl/pc_fetch_seq.sv
// Fetch-stage program-counter sequencer: IDLE/RUN/HALTED control, same-cycle
// branch resolution through an external branch LUT, saturating retire counter.
module pc_fetch_seq #(
  parameter int unsigned          PC_W     = 10,
  parameter logic [PC_W-1:0]      PROG_END = PC_W'(10'h3FF),
  parameter int unsigned          CNT_W    = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Stall,
  input  logic             Halt_req,
  input  logic             Branch_en,
  input  logic             Branch_uncond,
  input  logic             Branch_rel,
  input  logic             Flag,
  input  logic [4:0]       Target_idx,
  output logic [4:0]       Lut_index,
  input  logic [7:0]       Lut_value,
  output logic [PC_W-1:0]  Prog_ctr,
  output logic             Running,
  output logic             Done,
  output logic [CNT_W-1:0] Retired
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t            state;
  logic              taken;
  logic [PC_W-1:0]   br_target;
  logic [CNT_W-1:0]  ret_inc;

  assign Lut_index = Target_idx;

  always_comb begin
    taken     = Branch_en & (Branch_uncond | Flag);
    // Relative offsets are two's-complement; the signed cast sign-extends.
    br_target = Branch_rel ? (Prog_ctr + PC_W'($signed(Lut_value)))
                           : PC_W'(Lut_value);
    ret_inc   = (Retired == '1) ? Retired : (Retired + CNT_W'(1));
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state    <= IDLE;
      Prog_ctr <= '0;
      Retired  <= '0;
      Running  <= 1'b0;
      Done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          Prog_ctr <= '0;
          if (Start) begin
            state   <= RUN;
            Running <= 1'b1;
          end
        end
        RUN: begin
          if (Halt_req) begin
            state   <= HALTED;
            Running <= 1'b0;
            Done    <= 1'b1;
            Retired <= ret_inc;
          end else if (!Stall) begin
            Retired <= ret_inc;
            if (taken) begin
              Prog_ctr <= br_target;
            end else if (Prog_ctr == PROG_END) begin
              state   <= HALTED;
              Running <= 1'b0;
              Done    <= 1'b1;
            end else begin
              Prog_ctr <= Prog_ctr + PC_W'(1);
            end
          end
        end
        HALTED: begin
          if (Start) begin
            state    <= RUN;
            Running  <= 1'b1;
            Done     <= 1'b0;
            Prog_ctr <= '0;
            Retired  <= '0;
          end
        end
        default: begin
          state    <= IDLE;
          Prog_ctr <= '0;
          Running  <= 1'b0;
          Done     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_seq.sv
// Self-checking bench for pc_fetch_seq: directed vector table, corner sequences,
// and randomized traffic against a behavioural model.
module tb_pc_fetch_seq;

  logic       Clk = 1'b0;
  logic       Reset, Start, Stall, Halt_req, Branch_en, Branch_uncond, Branch_rel, Flag;
  logic [4:0] Target_idx;
  logic [7:0] Lut_value;

  logic [4:0]  lidx, lidx_s;
  logic [9:0]  pc, pc_s;
  logic        run, run_s, done, done_s;
  logic [15:0] ret;
  logic [3:0]  ret_s;

  always #5 Clk = ~Clk;

  pc_fetch_seq dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Stall(Stall), .Halt_req(Halt_req),
    .Branch_en(Branch_en), .Branch_uncond(Branch_uncond), .Branch_rel(Branch_rel),
    .Flag(Flag), .Target_idx(Target_idx), .Lut_index(lidx), .Lut_value(Lut_value),
    .Prog_ctr(pc), .Running(run), .Done(done), .Retired(ret)
  );

  pc_fetch_seq #(.CNT_W(4)) dut_s (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Stall(Stall), .Halt_req(Halt_req),
    .Branch_en(Branch_en), .Branch_uncond(Branch_uncond), .Branch_rel(Branch_rel),
    .Flag(Flag), .Target_idx(Target_idx), .Lut_index(lidx_s), .Lut_value(Lut_value),
    .Prog_ctr(pc_s), .Running(run_s), .Done(done_s), .Retired(ret_s)
  );

  typedef struct {
    bit st, sl, h, be, bu, br, f;
    int lut;
    int pc, run, done, ret;
  } vec_t;

  vec_t vecs[$];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // behavioural model: flags + plain integer arithmetic
  bit m_run, m_done;
  int m_pc, m_ret;

  function automatic void add(bit st, bit sl, bit h, bit be, bit bu, bit br, bit f,
                              int lut, int epc, int erun, int edone, int eret);
    vec_t v;
    v.st = st; v.sl = sl; v.h = h; v.be = be; v.bu = bu; v.br = br; v.f = f;
    v.lut = lut; v.pc = epc; v.run = erun; v.done = edone; v.ret = eret;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit st, input bit sl, input bit h, input bit be,
                       input bit bu, input bit br, input bit f, input int lut, input int tidx);
    Start = st; Stall = sl; Halt_req = h; Branch_en = be;
    Branch_uncond = bu; Branch_rel = br; Flag = f;
    Lut_value = 8'(lut); Target_idx = 5'(tidx);
  endtask

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  function automatic void model_reset();
    m_run = 0; m_done = 0; m_pc = 0; m_ret = 0;
  endfunction

  function automatic void model_step();
    int off;
    if (m_run) begin
      if (Halt_req) begin
        m_run = 0; m_done = 1; m_ret++;
      end else if (!Stall) begin
        m_ret++;
        if (Branch_en && (Branch_uncond || Flag)) begin
          if (Branch_rel) begin
            off  = (Lut_value > 127) ? int'(Lut_value) - 256 : int'(Lut_value);
            m_pc = ((m_pc + off) % 1024 + 1024) % 1024;
          end else begin
            m_pc = int'(Lut_value);
          end
        end else if (m_pc == 1023) begin
          m_run = 0; m_done = 1;
        end else begin
          m_pc = (m_pc + 1) % 1024;
        end
      end
    end else if (m_done) begin
      if (Start) begin
        m_run = 1; m_done = 0; m_pc = 0; m_ret = 0;
      end
    end else if (Start) begin
      m_run = 1;
    end
  endfunction

  task automatic check_model(input string tag);
    chk({tag, "_pc"},     int'(pc),     m_pc);
    chk({tag, "_run"},    int'(run),    int'(m_run));
    chk({tag, "_done"},   int'(done),   int'(m_done));
    chk({tag, "_ret"},    int'(ret),    sat(m_ret, 65535));
    chk({tag, "_ret_s"},  int'(ret_s),  sat(m_ret, 15));
    chk({tag, "_pc_s"},   int'(pc_s),   m_pc);
  endtask

  initial begin
    Reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);

    //   st sl h  be bu br f  lut   pc  run done ret
    add(0, 0, 0, 0, 0, 0, 0, 0,    0,   0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0,    0,   1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0,    1,   1, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 0,    2,   1, 0, 2);
    add(0, 0, 0, 0, 0, 0, 0, 0,    3,   1, 0, 3);
    add(0, 0, 0, 0, 0, 0, 0, 0,    4,   1, 0, 4);
    add(0, 0, 0, 0, 0, 0, 0, 0,    5,   1, 0, 5);
    add(0, 0, 0, 1, 1, 0, 0, 72,   72,  1, 0, 6);
    add(0, 0, 0, 1, 1, 0, 0, 20,   20,  1, 0, 7);
    add(0, 0, 0, 1, 0, 1, 1, 'hFC, 16,  1, 0, 8);
    add(0, 0, 0, 1, 1, 0, 0, 20,   20,  1, 0, 9);
    add(0, 0, 0, 1, 0, 1, 0, 'hFC, 21,  1, 0, 10);
    add(0, 0, 0, 1, 1, 0, 0, 9,    9,   1, 0, 11);
    add(0, 1, 0, 1, 1, 0, 0, 72,   9,   1, 0, 11);
    add(0, 1, 0, 1, 1, 0, 0, 72,   9,   1, 0, 11);
    add(0, 1, 0, 1, 1, 0, 0, 72,   9,   1, 0, 11);
    add(0, 0, 0, 0, 0, 0, 0, 0,    10,  1, 0, 12);
    add(0, 0, 0, 0, 0, 0, 0, 0,    11,  1, 0, 13);
    add(0, 0, 0, 0, 0, 0, 0, 0,    12,  1, 0, 14);
    add(0, 0, 1, 0, 0, 0, 0, 0,    12,  0, 1, 15);
    add(0, 0, 0, 1, 1, 0, 0, 72,   12,  0, 1, 15);
    add(1, 0, 0, 0, 0, 0, 0, 0,    0,   1, 0, 0);
    add(0, 1, 1, 0, 0, 0, 0, 0,    0,   0, 1, 1);
    add(1, 0, 0, 0, 0, 0, 0, 0,    0,   1, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0,    1,   1, 0, 1);
    add(0, 0, 0, 1, 1, 1, 0, 'hFF, 0,   1, 0, 2);
    add(0, 0, 0, 1, 1, 1, 0, 'hFF, 1023, 1, 0, 3);
    add(0, 0, 0, 1, 0, 0, 0, 50,   1023, 0, 1, 4);

    #2;
    chk("rst_pc", int'(pc), 0);
    chk("rst_run", int'(run), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_ret", int'(ret), 0);
    #10 Reset = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].st, vecs[i].sl, vecs[i].h, vecs[i].be, vecs[i].bu,
            vecs[i].br, vecs[i].f, vecs[i].lut, i);
      #1 chk("lut_index", int'(lidx), i % 32);
      @(posedge Clk); #1;
      chk($sformatf("v%0d_pc", i), int'(pc), vecs[i].pc);
      chk($sformatf("v%0d_run", i), int'(run), vecs[i].run);
      chk($sformatf("v%0d_done", i), int'(done), vecs[i].done);
      chk($sformatf("v%0d_ret", i), int'(ret), vecs[i].ret);
      chk($sformatf("v%0d_ret_s", i), int'(ret_s), sat(vecs[i].ret, 15));
    end

    // counter saturation on the narrow build, wide build keeps counting
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge Clk); #1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (20) @(posedge Clk);
    #1;
    chk("sat_pc", int'(pc), 20);
    chk("sat_ret", int'(ret), 20);
    chk("sat_ret_s", int'(ret_s), 15);
    chk("sat_run_s", int'(run_s), 1);

    // asynchronous reset between edges
    @(negedge Clk); #1 Reset = 1'b0;
    #1;
    chk("arst_pc", int'(pc), 0);
    chk("arst_run", int'(run), 0);
    chk("arst_done", int'(done), 0);
    chk("arst_ret", int'(ret), 0);
    chk("arst_ret_s", int'(ret_s), 0);
    @(negedge Clk) Reset = 1'b1;
    model_reset();

    for (int n = 0; n < 3000; n++) begin
      drive(($urandom % 8) == 0, ($urandom % 4) == 0, ($urandom % 64) == 0,
            ($urandom % 3) == 0, $urandom % 2, $urandom % 2, $urandom % 2,
            $urandom % 256, $urandom % 32);
      #1 chk("rnd_lut_index", int'(lidx), int'(Target_idx));
      model_step();
      @(posedge Clk); #1;
      check_model("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
